// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// the default fetch word used while the program image is being replaced.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LEN_HI = 3'd1,
      LEN_LO = 3'd2,
      DATA   = 3'd3,
      DONE   = 3'd4
   } state_t;

   localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0000;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream valid/ready channel feeding the loader; the source drives
// valid/data, the loader answers with ready.
interface imem_loader_if;

   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/imem_ram.sv
// Instruction RAM: DEPTH x 32, synchronous write, asynchronous read so the
// single-cycle datapath sees the fetched word in the same cycle.
module imem_ram #(
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [31:0]       wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [31:0]       rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed big-endian byte stream into instruction RAM while
// holding the CPU, then serves the combinational fetch port.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int          ADDR_W   = 8,
   parameter logic [31:0] NOP_WORD = NOP_WORD_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              start,
   imem_loader_if.slave      stream,
   input  logic [31:0]       fetch_addr,
   output logic [31:0]       fetch_ins,
   output logic              cpu_hold,
   output logic              done,
   output logic              overflow,
   output logic [ADDR_W:0]   word_cnt
);

   localparam int              DEPTH     = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);

   state_t      state, next_state;
   logic        ready_q, next_ready;
   logic        xfer, word_done, last_word, in_range, write_en, begin_load;
   logic [1:0]  lane;
   logic [15:0] len, word_idx, len_lo_val;
   logic [23:0] shift;
   logic [31:0] ram_rd;
   logic        unused_fetch_bits;

   function automatic logic [ADDR_W:0] sat_inc(input logic [ADDR_W:0] c);
      return (c == DEPTH_CNT) ? c : c + (ADDR_W+1)'(1);
   endfunction

   assign xfer            = stream.in_valid & ready_q;
   assign stream.in_ready = ready_q;
   assign len_lo_val      = {len[15:8], stream.in_data};
   assign word_done       = xfer && (state == DATA) && (lane == 2'd3);
   assign last_word       = (word_idx == len - 16'd1);
   // word_idx keeps counting past DEPTH so the whole stream is consumed
   assign in_range        = ((word_idx >> ADDR_W) == 16'd0);
   assign write_en        = word_done & in_range;
   assign begin_load      = start && ((state == IDLE) || (state == DONE));

   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (start) next_state = LEN_HI;
         LEN_HI:  if (xfer) next_state = LEN_LO;
         LEN_LO:  if (xfer) next_state = (len_lo_val == 16'd0) ? DONE : DATA;
         DATA:    if (word_done && last_word) next_state = DONE;
         DONE:    if (start) next_state = LEN_HI;
         default: next_state = IDLE;
      endcase
      next_ready = (next_state == LEN_HI) || (next_state == LEN_LO) ||
                   (next_state == DATA);
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         ready_q <= 1'b0;
      end else begin
         state   <= next_state;
         ready_q <= next_ready;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         lane     <= 2'd0;
         word_idx <= 16'd0;
         word_cnt <= '0;
         overflow <= 1'b0;
      end else if (begin_load) begin
         lane     <= 2'd0;
         word_idx <= 16'd0;
         word_cnt <= '0;
         overflow <= 1'b0;
      end else begin
         if (xfer && (state == LEN_LO) && ({1'b0, len_lo_val} > 17'(DEPTH)))
            overflow <= 1'b1;
         if (xfer && (state == DATA))
            lane <= lane + 2'd1;
         if (word_done) begin
            word_idx <= word_idx + 16'd1;
            word_cnt <= sat_inc(word_cnt);
         end
      end
   end

   // Length and word assembly registers carry data only; no reset needed
   always_ff @(posedge CLK) begin
      if (xfer && (state == LEN_HI)) len[15:8] <= stream.in_data;
      if (xfer && (state == LEN_LO)) len[7:0]  <= stream.in_data;
      if (xfer && (state == DATA))   shift     <= {shift[15:0], stream.in_data};
   end

   imem_ram #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (CLK),
      .we    (write_en),
      .waddr (word_cnt[ADDR_W-1:0]),
      .wdata ({shift, stream.in_data}),
      .raddr (fetch_addr[ADDR_W+1:2]),
      .rdata (ram_rd)
   );

   assign cpu_hold          = (state != DONE);
   assign done              = (state == DONE);
   assign fetch_ins         = (state == DONE) ? ram_rd : NOP_WORD;
   assign unused_fetch_bits = ^{fetch_addr[31:ADDR_W+2], fetch_addr[1:0]};

endmodule
